// File: rtl/issue_sequencer.sv
// In-order instruction issue sequencer: a small FIFO feeding an IDLE/EXEC/WB
// FSM that holds each instruction for a fixed number of cycles before write-back.
module issue_sequencer #(
   parameter int ins_width = 18,
   parameter int depth     = 4,
   parameter int hold      = 2,
   parameter int cnt_width = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ins_width-1:0] in_ins,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 flush,
   output logic [ins_width-1:0] ins,
   output logic                 ins_we,
   output logic                 busy,
   output logic [cnt_width-1:0] retired
);

   localparam int PW = (depth > 1) ? $clog2(depth) : 1;
   localparam int HW = (hold > 1) ? $clog2(hold) : 1;

   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

   logic [ins_width-1:0] mem_q [depth];
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [PW:0]          count_q, count_d;
   state_t               state_q, state_d;
   logic [HW-1:0]        hold_cnt_q, hold_cnt_d;
   logic [ins_width-1:0] ins_q, ins_d;
   logic                 ins_we_q, ins_we_d;
   logic [cnt_width-1:0] retired_q, retired_d;
   logic                 full, empty, push, pop;

   assign full     = (count_q == (PW+1)'(depth));
   assign empty    = (count_q == '0);
   assign in_ready = !full && !rst;
   assign push     = in_valid && in_ready && !flush;

   assign ins     = ins_q;
   assign ins_we  = ins_we_q;
   assign busy    = (state_q != IDLE);
   assign retired = retired_q;

   // Sequencing uses only occupancy, never the opcode bits.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      ins_d      = ins_q;
      retired_d  = retired_q;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               ins_d      = mem_q[rd_ptr_q];
               hold_cnt_d = '0;
               state_d    = EXEC;
            end
         end
         EXEC: begin
            if (hold_cnt_q == HW'(hold - 1)) begin
               state_d = WB;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         WB: begin
            retired_d = retired_q + 1'b1;
            if (!empty) begin
               pop        = 1'b1;
               ins_d      = mem_q[rd_ptr_q];
               hold_cnt_d = '0;
               state_d    = EXEC;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Flush discards the in-flight instruction: no pop, no count, ins kept.
      if (flush) begin
         state_d    = IDLE;
         pop        = 1'b0;
         ins_d      = ins_q;
         retired_d  = retired_q;
         hold_cnt_d = '0;
      end
      ins_we_d = (state_d == WB);
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_ins;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         state_q    <= IDLE;
         hold_cnt_q <= '0;
         ins_q      <= '0;
         ins_we_q   <= 1'b0;
         retired_q  <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         ins_q      <= ins_d;
         ins_we_q   <= ins_we_d;
         retired_q  <= retired_d;
      end
   end

endmodule
